// File: rtl/baud_gen.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | baud_gen : fractional baud-rate generator (oversample/bit ticks)   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module baud_gen #(
  parameter int WIDTH      = 16,
  parameter int FRAC_BITS  = 4,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk_in,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [WIDTH-1:0]     divisor,
  input  logic [FRAC_BITS-1:0] frac,
  input  logic                 load,
  output logic                 tick_os,
  output logic                 tick_bit,
  output logic                 clk_out,
  output logic                 cfg_err
);

  localparam int OS_W = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [OS_W-1:0]  c_os_last = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0]  c_os_half = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [WIDTH-1:0] c_min_div = WIDTH'(2);

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     act_div_q, act_div_d, sh_div_q, sh_div_d;
  logic [FRAC_BITS-1:0] act_frac_q, act_frac_d, sh_frac_q, sh_frac_d;
  logic                 pend_q, pend_d;
  logic [WIDTH:0]       cnt_q, cnt_d;
  logic [FRAC_BITS-1:0] acc_q, acc_d;
  logic [OS_W-1:0]      os_cnt_q, os_cnt_d;
  logic                 tick_os_q, tick_os_d, tick_bit_q, tick_bit_d;
  logic                 clk_out_q, clk_out_d, cfg_err_q, cfg_err_d;

  logic [WIDTH-1:0]     w_div_clamped, w_use_div;
  logic [FRAC_BITS-1:0] w_use_frac;
  logic [FRAC_BITS:0]   w_acc_sum;
  logic [WIDTH:0]       w_period_m1;

  // A pending shadow value takes effect for the period starting at this boundary.
  assign w_div_clamped = (divisor < c_min_div) ? c_min_div : divisor;
  assign w_use_div     = pend_q ? sh_div_q  : act_div_q;
  assign w_use_frac    = pend_q ? sh_frac_q : act_frac_q;
  assign w_acc_sum     = {1'b0, acc_q} + {1'b0, w_use_frac};
  assign w_period_m1   = {1'b0, w_use_div} + {{WIDTH{1'b0}}, w_acc_sum[FRAC_BITS]}
                         - (WIDTH+1)'(1);

  always_comb begin
    state_d    = state_q;
    act_div_d  = act_div_q;
    act_frac_d = act_frac_q;
    sh_div_d   = sh_div_q;
    sh_frac_d  = sh_frac_q;
    pend_d     = pend_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    os_cnt_d   = os_cnt_q;
    tick_os_d  = 1'b0;
    tick_bit_d = 1'b0;
    clk_out_d  = clk_out_q;
    cfg_err_d  = cfg_err_q;

    if (load) cfg_err_d = (divisor < c_min_div);

    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = RUN;
          cnt_d   = w_period_m1;
          acc_d   = w_acc_sum[FRAC_BITS-1:0];
        end
      end
      RUN: begin
        if (!enable) begin
          state_d   = IDLE;
          cnt_d     = '0;
          acc_d     = '0;
          os_cnt_d  = '0;
          pend_d    = 1'b0;
          clk_out_d = 1'b0;
          if (pend_q) begin
            act_div_d  = sh_div_q;
            act_frac_d = sh_frac_q;
          end
        end else if (cnt_q == '0) begin
          tick_os_d  = 1'b1;
          cnt_d      = w_period_m1;
          acc_d      = w_acc_sum[FRAC_BITS-1:0];
          tick_bit_d = (os_cnt_q == c_os_last);
          os_cnt_d   = (os_cnt_q == c_os_last) ? '0 : os_cnt_q + OS_W'(1);
          if ((os_cnt_q == c_os_half) || (os_cnt_q == c_os_last)) clk_out_d = ~clk_out_q;
          if (pend_q) begin
            act_div_d  = sh_div_q;
            act_frac_d = sh_frac_q;
            pend_d     = 1'b0;
          end
        end else begin
          cnt_d = cnt_q - (WIDTH+1)'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Applied last so a load on a boundary lands in the shadow for the next one.
    if (load) begin
      if (enable) begin
        sh_div_d  = w_div_clamped;
        sh_frac_d = frac;
        pend_d    = 1'b1;
      end else begin
        act_div_d  = w_div_clamped;
        act_frac_d = frac;
      end
    end
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      act_div_q  <= c_min_div;
      act_frac_q <= '0;
      sh_div_q   <= c_min_div;
      sh_frac_q  <= '0;
      pend_q     <= 1'b0;
      cnt_q      <= '0;
      acc_q      <= '0;
      os_cnt_q   <= '0;
      tick_os_q  <= 1'b0;
      tick_bit_q <= 1'b0;
      clk_out_q  <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      act_div_q  <= act_div_d;
      act_frac_q <= act_frac_d;
      sh_div_q   <= sh_div_d;
      sh_frac_q  <= sh_frac_d;
      pend_q     <= pend_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      os_cnt_q   <= os_cnt_d;
      tick_os_q  <= tick_os_d;
      tick_bit_q <= tick_bit_d;
      clk_out_q  <= clk_out_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

  assign tick_os  = tick_os_q;
  assign tick_bit = tick_bit_q;
  assign clk_out  = clk_out_q;
  assign cfg_err  = cfg_err_q;

endmodule
`default_nettype wire

// File: tb/tb_baud_gen.sv
`default_nettype none
// Directed bench for baud_gen with default parameters (16/4/16).
module tb_baud_gen;

  logic        clk_in  = 1'b0;
  logic        reset   = 1'b0;
  logic        enable  = 1'b0;
  logic        load    = 1'b0;
  logic [15:0] divisor = '0;
  logic [3:0]  frac    = '0;
  logic        tick_os, tick_bit, clk_out, cfg_err;

  int cyc   = 0;
  int n_cmp = 0;
  int n_err = 0;

  baud_gen #(.WIDTH(16), .FRAC_BITS(4), .OVERSAMPLE(16)) dut (
    .clk_in  (clk_in),
    .reset   (reset),
    .enable  (enable),
    .divisor (divisor),
    .frac    (frac),
    .load    (load),
    .tick_os (tick_os),
    .tick_bit(tick_bit),
    .clk_out (clk_out),
    .cfg_err (cfg_err)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc = cyc + 1;

  // Returns the edge index at which the next tick_os rose, or -1 on timeout.
  task automatic next_tick(output int t);
    t = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk_in);
      if (tick_os === 1'b1) begin
        t = cyc;
        break;
      end
    end
  endtask

  task automatic wait_until(input int c);
    for (int i = 0; i < 1000; i++) begin
      if (cyc >= c) break;
      @(negedge clk_in);
    end
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] f);
    divisor = d;
    frac    = f;
    load    = 1'b1;
    @(negedge clk_in);
    load    = 1'b0;
  endtask

  task automatic start_run(output int e0);
    enable = 1'b1;
    @(posedge clk_in);
    #1;
    e0 = cyc;
  endtask

  task automatic stop_run;
    @(negedge clk_in);
    enable = 1'b0;
    @(negedge clk_in);
    @(negedge clk_in);
  endtask

  task automatic test_reset;
    reset = 1'b0;
    #2;
    n_cmp++; if (tick_os !== 1'b0)  begin n_err++; $display("FAIL rst_tick_os: got %b expected 0", tick_os); end
    n_cmp++; if (tick_bit !== 1'b0) begin n_err++; $display("FAIL rst_tick_bit: got %b expected 0", tick_bit); end
    n_cmp++; if (clk_out !== 1'b0)  begin n_err++; $display("FAIL rst_clk_out: got %b expected 0", clk_out); end
    n_cmp++; if (cfg_err !== 1'b0)  begin n_err++; $display("FAIL rst_cfg_err: got %b expected 0", cfg_err); end
    @(negedge clk_in);
    reset = 1'b1;
    repeat (3) @(negedge clk_in);
    n_cmp++; if (tick_os !== 1'b0)  begin n_err++; $display("FAIL idle_tick_os: got %b expected 0", tick_os); end
  endtask

  task automatic test_integer;
    int e0, t;
    do_load(16'd10, 4'd0);
    start_run(e0);
    for (int k = 1; k <= 16; k++) begin
      next_tick(t);
      n_cmp++;
      if (t !== e0 + 10 * k) begin
        n_err++; $display("FAIL int_tick%0d: got edge %0d expected %0d", k, t - e0, 10 * k);
      end
      n_cmp++;
      if (tick_bit !== (k == 16)) begin
        n_err++; $display("FAIL int_bit%0d: got %b expected %b", k, tick_bit, (k == 16));
      end
      n_cmp++;
      if (clk_out !== (k >= 8 && k < 16)) begin
        n_err++; $display("FAIL int_clk%0d: got %b expected %b", k, clk_out, (k >= 8 && k < 16));
      end
    end
    stop_run;
  endtask

  task automatic test_fractional;
    int e0, t, prev, exp_p;
    do_load(16'd5, 4'd4);
    start_run(e0);
    prev = e0;
    t    = e0;
    for (int k = 1; k <= 16; k++) begin
      next_tick(t);
      exp_p = (k % 4 == 0) ? 6 : 5;
      n_cmp++;
      if (t - prev !== exp_p) begin
        n_err++; $display("FAIL frac_period%0d: got %0d expected %0d", k, t - prev, exp_p);
      end
      prev = t;
    end
    n_cmp++;
    if (t - e0 !== 84) begin
      n_err++; $display("FAIL frac_span: got %0d expected 84", t - e0);
    end
    stop_run;
  endtask

  task automatic test_live_reload;
    int e0, t1, t2, t3, t4;
    do_load(16'd10, 4'd0);
    start_run(e0);
    next_tick(t1);
    n_cmp++; if (t1 !== e0 + 10) begin n_err++; $display("FAIL mid_t1: got %0d expected %0d", t1 - e0, 10); end
    divisor = 16'd4; load = 1'b1;
    @(negedge clk_in);
    load = 1'b0;
    next_tick(t2);
    next_tick(t3);
    next_tick(t4);
    n_cmp++; if (t2 - t1 !== 10) begin n_err++; $display("FAIL mid_p2: got %0d expected 10", t2 - t1); end
    n_cmp++; if (t3 - t2 !== 4)  begin n_err++; $display("FAIL mid_p3: got %0d expected 4", t3 - t2); end
    n_cmp++; if (t4 - t3 !== 4)  begin n_err++; $display("FAIL mid_p4: got %0d expected 4", t4 - t3); end
    stop_run;

    do_load(16'd10, 4'd0);
    start_run(e0);
    wait_until(e0 + 9);
    divisor = 16'd4; load = 1'b1;
    @(negedge clk_in);
    load = 1'b0;
    n_cmp++; if (tick_os !== 1'b1) begin n_err++; $display("FAIL edge_t1: got %b expected 1", tick_os); end
    t1 = cyc;
    next_tick(t2);
    next_tick(t3);
    n_cmp++; if (t2 - t1 !== 10) begin n_err++; $display("FAIL edge_p2: got %0d expected 10", t2 - t1); end
    n_cmp++; if (t3 - t2 !== 4)  begin n_err++; $display("FAIL edge_p3: got %0d expected 4", t3 - t2); end
    stop_run;
  endtask

  task automatic test_clamp;
    int e0, t1, t2, t3, t4, t5;
    do_load(16'd1, 4'd0);
    n_cmp++; if (cfg_err !== 1'b1) begin n_err++; $display("FAIL clamp_err_set: got %b expected 1", cfg_err); end
    start_run(e0);
    next_tick(t1);
    next_tick(t2);
    n_cmp++; if (t1 - e0 !== 2) begin n_err++; $display("FAIL clamp_p1: got %0d expected 2", t1 - e0); end
    n_cmp++; if (t2 - t1 !== 2) begin n_err++; $display("FAIL clamp_p2: got %0d expected 2", t2 - t1); end
    divisor = 16'd3; load = 1'b1;
    @(negedge clk_in);
    load = 1'b0;
    n_cmp++; if (cfg_err !== 1'b0) begin n_err++; $display("FAIL clamp_err_clr: got %b expected 0", cfg_err); end
    next_tick(t3);
    next_tick(t4);
    next_tick(t5);
    n_cmp++; if (t3 - t2 !== 2) begin n_err++; $display("FAIL clamp_p3: got %0d expected 2", t3 - t2); end
    n_cmp++; if (t4 - t3 !== 3) begin n_err++; $display("FAIL clamp_p4: got %0d expected 3", t4 - t3); end
    n_cmp++; if (t5 - t4 !== 3) begin n_err++; $display("FAIL clamp_p5: got %0d expected 3", t5 - t4); end
    stop_run;
  endtask

  task automatic test_disable_reset;
    int e0, t;
    do_load(16'd10, 4'd0);
    start_run(e0);
    for (int k = 1; k <= 9; k++) next_tick(t);
    n_cmp++; if (t !== e0 + 90)   begin n_err++; $display("FAIL dis_t9: got %0d expected 90", t - e0); end
    n_cmp++; if (clk_out !== 1'b1) begin n_err++; $display("FAIL dis_clk_hi: got %b expected 1", clk_out); end
    // Drop enable on the edge that would otherwise have been the 10th tick.
    wait_until(t + 9);
    enable = 1'b0;
    @(negedge clk_in);
    n_cmp++; if (tick_os !== 1'b0) begin n_err++; $display("FAIL dis_tick_os: got %b expected 0", tick_os); end
    n_cmp++; if (clk_out !== 1'b0) begin n_err++; $display("FAIL dis_clk_out: got %b expected 0", clk_out); end

    start_run(e0);
    for (int k = 1; k <= 8; k++) begin
      next_tick(t);
      if (k == 1) begin
        n_cmp++; if (t !== e0 + 10) begin n_err++; $display("FAIL re_t1: got %0d expected 10", t - e0); end
      end
      if (k == 7) begin
        n_cmp++; if (clk_out !== 1'b0) begin n_err++; $display("FAIL re_clk7: got %b expected 0", clk_out); end
      end
    end
    n_cmp++; if (clk_out !== 1'b1) begin n_err++; $display("FAIL re_clk8: got %b expected 1", clk_out); end

    divisor = 16'd1; load = 1'b1;
    @(negedge clk_in);
    load = 1'b0;
    n_cmp++; if (cfg_err !== 1'b1) begin n_err++; $display("FAIL run_err_set: got %b expected 1", cfg_err); end
    @(negedge clk_in);
    #2;
    reset = 1'b0;
    #1;
    n_cmp++; if (clk_out !== 1'b0) begin n_err++; $display("FAIL arst_clk_out: got %b expected 0", clk_out); end
    n_cmp++; if (cfg_err !== 1'b0) begin n_err++; $display("FAIL arst_cfg_err: got %b expected 0", cfg_err); end
    n_cmp++; if (tick_os !== 1'b0) begin n_err++; $display("FAIL arst_tick_os: got %b expected 0", tick_os); end
    enable = 1'b0;
    @(negedge clk_in);
    reset = 1'b1;
    repeat (3) @(negedge clk_in);
    n_cmp++; if (tick_os !== 1'b0) begin n_err++; $display("FAIL post_rst_idle: got %b expected 0", tick_os); end
    // Active divisor is back to its reset value of 2.
    start_run(e0);
    next_tick(t);
    n_cmp++; if (t - e0 !== 2) begin n_err++; $display("FAIL post_rst_p: got %0d expected 2", t - e0); end
    stop_run;
  endtask

  initial begin
    test_reset;
    test_integer;
    test_fractional;
    test_live_reload;
    test_clamp;
    test_disable_reset;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
